instr_dispatch: RTL and testbench

- Sits directly downstream of the request queue.
- Consumes packed instructions `{opcode, key_addr, text_addr}`, decodes the opcode and launches the AES or SHA core with a one-cycle start pulse.
- Tracks each core's busy state and feeds per-core readiness back to the queue.
- Returns one completion record per finished operation to the host side over a valid/ready channel.

---
 rtl/instr_dispatch.sv | 269 ++++++++++++++++++++++++++
 tb/tb_instr_dispatch.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_dispatch.sv
// rtl/instr_dispatch.sv - decodes queued instructions, launches AES/SHA cores, returns completion records
// Optional feature macro: DISPATCH_TIMEOUT_EN (adds TIMEOUT_CYCLES and timeout_err).
module instr_dispatch #(
    parameter int ADDRW   = 8,
    parameter int OPCODEW = 2
`ifdef DISPATCH_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       instr_valid,
    input  logic [2*ADDRW+OPCODEW-1:0] instr,
    output logic                       instr_ack,
    output logic                       aes_rdy,
    output logic                       sha_rdy,
    output logic                       aes_start,
    output logic                       aes_mode,
    output logic [ADDRW-1:0]           aes_key_addr,
    output logic [ADDRW-1:0]           aes_text_addr,
    input  logic                       aes_done,
    output logic                       sha_start,
    output logic [ADDRW-1:0]           sha_text_addr,
    input  logic                       sha_done,
    output logic                       cmpl_valid,
    output logic [OPCODEW-1:0]         cmpl_opcode,
    output logic [ADDRW-1:0]           cmpl_addr,
    input  logic                       cmpl_ready,
    output logic                       err_opcode
`ifdef DISPATCH_TIMEOUT_EN
    ,
    output logic                       timeout_err
`endif
);

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_RUN  = 2'd1,
        CH_DONE = 2'd2
    } ch_state_e;

    localparam logic [OPCODEW-1:0] OP_AES_ENC = OPCODEW'(0);
    localparam logic [OPCODEW-1:0] OP_AES_DEC = OPCODEW'(1);
    localparam logic [OPCODEW-1:0] OP_SHA     = OPCODEW'(2);

    // Instruction fields
    logic [OPCODEW-1:0] dec_op;
    logic [ADDRW-1:0]   dec_key;
    logic [ADDRW-1:0]   dec_text;

    assign dec_op   = instr[2*ADDRW+OPCODEW-1 -: OPCODEW];
    assign dec_key  = instr[2*ADDRW-1 -: ADDRW];
    assign dec_text = instr[ADDRW-1:0];

    // Channel state and latched launch parameters
    ch_state_e          aes_st_q;
    ch_state_e          sha_st_q;
    logic               aes_start_q;
    logic               aes_mode_q;
    logic [OPCODEW-1:0] aes_op_q;
    logic [ADDRW-1:0]   aes_key_q;
    logic [ADDRW-1:0]   aes_text_q;
    logic               sha_start_q;
    logic [ADDRW-1:0]   sha_text_q;

    // Completion register; owner says which channel the held record belongs to
    logic               cmpl_valid_q;
    logic [OPCODEW-1:0] cmpl_opcode_q;
    logic [ADDRW-1:0]   cmpl_addr_q;
    logic               cmpl_own_sha_q;

    logic is_aes_op;
    logic is_sha_op;
    logic is_rsv_op;
    logic aes_acc;
    logic sha_acc;
    logic rsv_acc;
    logic cmpl_hs;
    logic aes_done_vld;
    logic sha_done_vld;

    // Upper opcode bits beyond the 2-bit decode must be zero to match a channel
    assign is_aes_op = (dec_op == OP_AES_ENC) || (dec_op == OP_AES_DEC);
    assign is_sha_op = (dec_op == OP_SHA);
    assign is_rsv_op = !is_aes_op && !is_sha_op;

    // Acceptance: one instruction per cycle, only into an idle target channel
    assign aes_acc = !rst && instr_valid && is_aes_op && (aes_st_q == CH_IDLE);
    assign sha_acc = !rst && instr_valid && is_sha_op && (sha_st_q == CH_IDLE);
    assign rsv_acc = !rst && instr_valid && is_rsv_op;

    assign instr_ack  = aes_acc || sha_acc || rsv_acc;
    assign err_opcode = rsv_acc;

    assign aes_rdy = (aes_st_q == CH_IDLE);
    assign sha_rdy = (sha_st_q == CH_IDLE);

    // A done coinciding with the start pulse cannot come from a real core; drop it
    assign aes_done_vld = aes_done && !aes_start_q;
    assign sha_done_vld = sha_done && !sha_start_q;

    assign cmpl_hs = cmpl_valid_q && cmpl_ready;

    assign aes_start     = aes_start_q;
    assign aes_mode      = aes_mode_q;
    assign aes_key_addr  = aes_key_q;
    assign aes_text_addr = aes_text_q;
    assign sha_start     = sha_start_q;
    assign sha_text_addr = sha_text_q;
    assign cmpl_valid    = cmpl_valid_q;
    assign cmpl_opcode   = cmpl_opcode_q;
    assign cmpl_addr     = cmpl_addr_q;

`ifdef DISPATCH_TIMEOUT_EN
    localparam int             TCW    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TCW-1:0] T_LAST = TCW'(TIMEOUT_CYCLES - 1);

    logic [TCW-1:0] aes_cnt_q;
    logic [TCW-1:0] sha_cnt_q;
    logic           aes_to_q;
    logic           sha_to_q;
    logic           aes_to_pulse_q;
    logic           sha_to_pulse_q;

    assign timeout_err = aes_to_pulse_q || sha_to_pulse_q;
`endif

    // AES channel FSM: IDLE -> RUN -> DONE -> IDLE, start pulse one cycle after accept
    always_ff @(posedge clk) begin
        if (rst) begin
            aes_st_q       <= CH_IDLE;
            aes_start_q    <= 1'b0;
            aes_mode_q     <= 1'b0;
            aes_op_q       <= '0;
            aes_key_q      <= '0;
            aes_text_q     <= '0;
`ifdef DISPATCH_TIMEOUT_EN
            aes_cnt_q      <= '0;
            aes_to_q       <= 1'b0;
            aes_to_pulse_q <= 1'b0;
`endif
        end else begin
            aes_start_q    <= 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
            aes_to_pulse_q <= 1'b0;
`endif
            case (aes_st_q)
                CH_IDLE: begin
                    if (aes_acc) begin
                        aes_st_q    <= CH_RUN;
                        aes_start_q <= 1'b1;
                        aes_mode_q  <= dec_op[0];
                        aes_op_q    <= dec_op;
                        aes_key_q   <= dec_key;
                        aes_text_q  <= dec_text;
`ifdef DISPATCH_TIMEOUT_EN
                        aes_cnt_q   <= '0;
                        aes_to_q    <= 1'b0;
`endif
                    end
                end
                CH_RUN: begin
                    if (aes_done_vld) begin
                        aes_st_q <= CH_DONE;
`ifdef DISPATCH_TIMEOUT_EN
                    end else if (aes_cnt_q == T_LAST) begin
                        aes_st_q       <= CH_DONE;
                        aes_to_q       <= 1'b1;
                        aes_to_pulse_q <= 1'b1;
                    end else begin
                        aes_cnt_q <= aes_cnt_q + 1'b1;
`endif
                    end
                end
                CH_DONE: begin
                    if (cmpl_hs && !cmpl_own_sha_q) begin
                        aes_st_q <= CH_IDLE;
                    end
                end
                default: aes_st_q <= CH_IDLE;
            endcase
        end
    end

    // SHA channel FSM: same life cycle as AES, single opcode so only the text address is kept
    always_ff @(posedge clk) begin
        if (rst) begin
            sha_st_q       <= CH_IDLE;
            sha_start_q    <= 1'b0;
            sha_text_q     <= '0;
`ifdef DISPATCH_TIMEOUT_EN
            sha_cnt_q      <= '0;
            sha_to_q       <= 1'b0;
            sha_to_pulse_q <= 1'b0;
`endif
        end else begin
            sha_start_q    <= 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
            sha_to_pulse_q <= 1'b0;
`endif
            case (sha_st_q)
                CH_IDLE: begin
                    if (sha_acc) begin
                        sha_st_q    <= CH_RUN;
                        sha_start_q <= 1'b1;
                        sha_text_q  <= dec_text;
`ifdef DISPATCH_TIMEOUT_EN
                        sha_cnt_q   <= '0;
                        sha_to_q    <= 1'b0;
`endif
                    end
                end
                CH_RUN: begin
                    if (sha_done_vld) begin
                        sha_st_q <= CH_DONE;
`ifdef DISPATCH_TIMEOUT_EN
                    end else if (sha_cnt_q == T_LAST) begin
                        sha_st_q       <= CH_DONE;
                        sha_to_q       <= 1'b1;
                        sha_to_pulse_q <= 1'b1;
                    end else begin
                        sha_cnt_q <= sha_cnt_q + 1'b1;
`endif
                    end
                end
                CH_DONE: begin
                    if (cmpl_hs && cmpl_own_sha_q) begin
                        sha_st_q <= CH_IDLE;
                    end
                end
                default: sha_st_q <= CH_IDLE;
            endcase
        end
    end

    // Completion register: load when empty (AES has priority), hold until handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            cmpl_valid_q   <= 1'b0;
            cmpl_opcode_q  <= '0;
            cmpl_addr_q    <= '0;
            cmpl_own_sha_q <= 1'b0;
        end else if (cmpl_hs) begin
            cmpl_valid_q <= 1'b0;
        end else if (!cmpl_valid_q) begin
            if (aes_st_q == CH_DONE) begin
                cmpl_valid_q   <= 1'b1;
                cmpl_opcode_q  <= aes_op_q;
                cmpl_own_sha_q <= 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
                cmpl_addr_q    <= aes_to_q ? '1 : aes_text_q;
`else
                cmpl_addr_q    <= aes_text_q;
`endif
            end else if (sha_st_q == CH_DONE) begin
                cmpl_valid_q   <= 1'b1;
                cmpl_opcode_q  <= OP_SHA;
                cmpl_own_sha_q <= 1'b1;
`ifdef DISPATCH_TIMEOUT_EN
                cmpl_addr_q    <= sha_to_q ? '1 : sha_text_q;
`else
                cmpl_addr_q    <= sha_text_q;
`endif
            end
        end
    end

endmodule

// File: tb/tb_instr_dispatch.sv
// tb/tb_instr_dispatch.sv - directed and randomized checks of instr_dispatch against a transaction model
module tb_instr_dispatch;

    localparam int ADDRW   = 8;
    localparam int OPCODEW = 2;
    localparam int IW      = 2*ADDRW + OPCODEW;
`ifdef DISPATCH_TIMEOUT_EN
    localparam int TO      = 8;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          instr_valid = 1'b0;
    logic [IW-1:0] instr = '0;
    logic          aes_done = 1'b0;
    logic          sha_done = 1'b0;
    logic          cmpl_ready = 1'b0;

    logic               instr_ack, aes_rdy, sha_rdy, aes_start, aes_mode, sha_start;
    logic [ADDRW-1:0]   aes_key_addr, aes_text_addr, sha_text_addr, cmpl_addr;
    logic               cmpl_valid, err_opcode;
    logic [OPCODEW-1:0] cmpl_opcode;
`ifdef DISPATCH_TIMEOUT_EN
    logic               timeout_err;
`endif

    always #5 clk = ~clk;

    instr_dispatch #(
        .ADDRW(ADDRW),
        .OPCODEW(OPCODEW)
`ifdef DISPATCH_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(TO)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .instr_valid(instr_valid),
        .instr(instr),
        .instr_ack(instr_ack),
        .aes_rdy(aes_rdy),
        .sha_rdy(sha_rdy),
        .aes_start(aes_start),
        .aes_mode(aes_mode),
        .aes_key_addr(aes_key_addr),
        .aes_text_addr(aes_text_addr),
        .aes_done(aes_done),
        .sha_start(sha_start),
        .sha_text_addr(sha_text_addr),
        .sha_done(sha_done),
        .cmpl_valid(cmpl_valid),
        .cmpl_opcode(cmpl_opcode),
        .cmpl_addr(cmpl_addr),
        .cmpl_ready(cmpl_ready),
        .err_opcode(err_opcode)
`ifdef DISPATCH_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Transaction-level model: a channel is busy from acceptance until its record is handshaken
    bit       a_busy, a_fin, a_startnow;
    bit [1:0] a_op;
    bit [7:0] a_key, a_txt;
    bit       s_busy, s_fin, s_startnow;
    bit [7:0] s_txt;
    bit       p_full, p_sha;
    bit [1:0] p_op;
    bit [7:0] p_addr;
    int       a_runc, s_runc;
    bit       a_tout, s_tout, to_pulse;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        a_busy = 0; a_fin = 0; a_startnow = 0; a_op = 0; a_key = 0; a_txt = 0;
        s_busy = 0; s_fin = 0; s_startnow = 0; s_txt = 0;
        p_full = 0; p_sha = 0; p_op = 0; p_addr = 0;
        a_runc = 0; s_runc = 0; a_tout = 0; s_tout = 0; to_pulse = 0;
    endtask

    task automatic drive(input bit r, input bit v, input logic [IW-1:0] ins,
                         input bit ad, input bit sd, input bit rdy);
        rst = r; instr_valid = v; instr = ins;
        aes_done = ad; sha_done = sd; cmpl_ready = rdy;
        @(negedge clk);
    endtask

    // Compare every output with the model for the current cycle, advance the model, move past the edge
    task automatic model_cycle();
        bit [1:0] op;
        bit       acc_a, acc_s, rsv, hs, adv, sdv;
        op  = instr[IW-1:2*ADDRW];
        rsv = (op == 2'd3);
        if (rst) begin
            check("rst_ack", instr_ack, 0);
            check("rst_err", err_opcode, 0);
            model_reset();
        end else begin
            acc_a = instr_valid && (op < 2'd2) && !a_busy;
            acc_s = instr_valid && (op == 2'd2) && !s_busy;
            check("m_ack", instr_ack, instr_valid && (rsv || acc_a || acc_s));
            check("m_err", err_opcode, instr_valid && rsv);
            check("m_aes_rdy", aes_rdy, !a_busy);
            check("m_sha_rdy", sha_rdy, !s_busy);
            check("m_aes_start", aes_start, a_startnow);
            check("m_sha_start", sha_start, s_startnow);
            check("m_cmpl_valid", cmpl_valid, p_full);
            if (p_full) begin
                check("m_cmpl_op", cmpl_opcode, p_op);
                check("m_cmpl_addr", cmpl_addr, p_addr);
            end
            if (a_busy) begin
                check("m_aes_mode", aes_mode, a_op[0]);
                check("m_aes_key", aes_key_addr, a_key);
                check("m_aes_text", aes_text_addr, a_txt);
            end
            if (s_busy) check("m_sha_text", sha_text_addr, s_txt);
`ifdef DISPATCH_TIMEOUT_EN
            check("m_timeout", timeout_err, to_pulse);
`endif
            adv = a_busy && !a_fin && aes_done && !a_startnow;
            sdv = s_busy && !s_fin && sha_done && !s_startnow;
            hs  = p_full && cmpl_ready;
            if (hs) begin
                if (p_sha) begin s_busy = 0; s_fin = 0; end
                else begin a_busy = 0; a_fin = 0; end
                p_full = 0;
            end else if (!p_full) begin
                if (a_fin) begin
                    p_full = 1; p_sha = 0; p_op = a_op; p_addr = a_tout ? 8'hFF : a_txt;
                end else if (s_fin) begin
                    p_full = 1; p_sha = 1; p_op = 2'd2; p_addr = s_tout ? 8'hFF : s_txt;
                end
            end
            to_pulse = 0;
            if (adv) a_fin = 1;
`ifdef DISPATCH_TIMEOUT_EN
            else if (a_busy && !a_fin) begin
                a_runc++;
                if (a_runc == TO) begin a_fin = 1; a_tout = 1; to_pulse = 1; end
            end
`endif
            if (sdv) s_fin = 1;
`ifdef DISPATCH_TIMEOUT_EN
            else if (s_busy && !s_fin) begin
                s_runc++;
                if (s_runc == TO) begin s_fin = 1; s_tout = 1; to_pulse = 1; end
            end
`endif
            a_startnow = acc_a;
            s_startnow = acc_s;
            if (acc_a) begin
                a_busy = 1; a_fin = 0; a_op = op; a_key = instr[15:8]; a_txt = instr[7:0];
                a_runc = 0; a_tout = 0;
            end
            if (acc_s) begin
                s_busy = 1; s_fin = 0; s_txt = instr[7:0]; s_runc = 0; s_tout = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [IW-1:0] ins_aes, ins_sha, ins_dec, ins_rsv, rnd;
        ins_aes = {2'b00, 8'h12, 8'h34};
        ins_sha = {2'b10, 8'hAB, 8'h56};
        ins_dec = {2'b01, 8'h77, 8'h88};
        ins_rsv = {2'b11, 8'h01, 8'h02};
        model_reset();

        drive(1, 0, '0, 0, 0, 0); model_cycle();
        drive(1, 0, '0, 0, 0, 0); model_cycle();

        // Reset state
        drive(0, 0, '0, 0, 0, 0);
        check("rst_aes_rdy", aes_rdy, 1);
        check("rst_sha_rdy", sha_rdy, 1);
        check("rst_cmpl_valid", cmpl_valid, 0);
        check("rst_aes_start", aes_start, 0);
        model_cycle();

        // AES encrypt launch
        drive(0, 1, ins_aes, 0, 0, 0);
        check("aes_ack", instr_ack, 1);
        model_cycle();
        drive(0, 0, '0, 0, 0, 0);
        check("aes_start_pulse", aes_start, 1);
        check("aes_mode_enc", aes_mode, 0);
        check("aes_key", aes_key_addr, 8'h12);
        check("aes_text", aes_text_addr, 8'h34);
        check("aes_busy", aes_rdy, 0);
        model_cycle();
        for (int i = 0; i < 2; i++) begin drive(0, 0, '0, 0, 0, 0); model_cycle(); end

        // SHA accepted while AES busy
        drive(0, 1, ins_sha, 0, 0, 0);
        check("sha_ack", instr_ack, 1);
        model_cycle();
        drive(0, 1, ins_dec, 0, 0, 0);
        check("sha_start_pulse", sha_start, 1);
        check("dec_blocked1", instr_ack, 0);
        model_cycle();
        drive(0, 1, ins_dec, 0, 0, 0);
        check("dec_blocked2", instr_ack, 0);
        model_cycle();

        // Simultaneous completion with back-pressure
        drive(0, 1, ins_dec, 1, 1, 0); model_cycle();
        drive(0, 1, ins_dec, 0, 0, 0); model_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, ins_dec, 0, 0, 0);
            check("aes_rec_valid", cmpl_valid, 1);
            check("aes_rec_op", cmpl_opcode, 2'b00);
            check("aes_rec_addr", cmpl_addr, 8'h34);
            check("dec_blocked3", instr_ack, 0);
            model_cycle();
        end
        drive(0, 1, ins_dec, 0, 0, 1);
        check("aes_rec_hs_addr", cmpl_addr, 8'h34);
        model_cycle();
        drive(0, 1, ins_dec, 0, 0, 0);
        check("aes_idle_again", aes_rdy, 1);
        check("dec_ack", instr_ack, 1);
        check("port_empty_gap", cmpl_valid, 0);
        model_cycle();
        drive(0, 0, '0, 0, 0, 0);
        check("dec_start", aes_start, 1);
        check("dec_mode", aes_mode, 1);
        check("sha_rec_valid", cmpl_valid, 1);
        check("sha_rec_op", cmpl_opcode, 2'b10);
        check("sha_rec_addr", cmpl_addr, 8'h56);
        model_cycle();
        drive(0, 0, '0, 0, 0, 1); model_cycle();

        // Reset while AES in RUN abandons the operation
        drive(1, 0, '0, 0, 0, 0); model_cycle();
        drive(0, 0, '0, 0, 0, 0);
        check("rst_mid_aes_rdy", aes_rdy, 1);
        check("rst_mid_cmpl", cmpl_valid, 0);
        model_cycle();
        drive(0, 0, '0, 1, 0, 1); model_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, '0, 0, 0, 1);
            check("no_rec_after_rst", cmpl_valid, 0);
            model_cycle();
        end

        // Reserved opcode
        drive(0, 1, ins_rsv, 0, 0, 0);
        check("rsv_ack", instr_ack, 1);
        check("rsv_err", err_opcode, 1);
        model_cycle();
        drive(0, 0, '0, 0, 0, 0);
        check("rsv_aes_rdy", aes_rdy, 1);
        check("rsv_sha_rdy", sha_rdy, 1);
        check("rsv_no_aes_start", aes_start, 0);
        check("rsv_no_sha_start", sha_start, 0);
        model_cycle();

`ifdef DISPATCH_TIMEOUT_EN
        // SHA with no done times out after TO cycles in RUN
        drive(0, 1, {2'b10, 8'h00, 8'h9A}, 0, 0, 0); model_cycle();
        for (int k = 1; k <= 12; k++) begin
            drive(0, 0, '0, 0, 0, (k >= 11));
            if (k == 9) check("timeout_pulse", timeout_err, 1);
            if (k == 11) begin
                check("to_rec_valid", cmpl_valid, 1);
                check("to_rec_op", cmpl_opcode, 2'b10);
                check("to_rec_addr", cmpl_addr, 8'hFF);
            end
            model_cycle();
        end
`endif

        // Randomized traffic including stray done pulses and back-pressure
        for (int c = 0; c < 800; c++) begin
            rnd = IW'($urandom);
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 6), rnd,
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 1) == 1));
            model_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
